mem_wb_pipe: RTL and testbench

- Holds the EX/MEM and MEM/WB pipeline registers of the MIPS core.
- Supplies the forwarding sources (mem_dst/mem_we/mem_data, wb_dst/wb_we/wb_data) consumed by the operand-forwarding muxes in ID.
- Detects load-use hazards and memory-wait freezes, and drives the stall/bubble controls for the front of the pipe.
- Sits between the EX stage outputs and the register-file write port.

---
 rtl/core_pkg.sv | 30 +++
 rtl/hazard_detect.sv | 52 +++++
 rtl/mem_wb_pipe.sv | 124 ++++++++++++
 tb/tb_mem_wb_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the MIPS core back-end.
//   DATA_W / REG_W : datapath and register-index widths
//   REG_ZERO       : index of the hard-wired zero register
//   stage_t        : one pipeline-stage record {valid, we, load, dst, data}
//   reg_hit()      : does the ID instruction read register d (d != r0)?
package core_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic              load;
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } stage_t;

  // r0 is never a dependency, so a match on index 0 is never a hit.
  function automatic logic reg_hit(input logic             use_rs,
                                   input logic             use_rt,
                                   input logic [REG_W-1:0] rs,
                                   input logic [REG_W-1:0] rt,
                                   input logic [REG_W-1:0] d);
    return (d != REG_ZERO) && ((use_rs && (rs == d)) || (use_rt && (rt == d)));
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Purely combinational hazard logic for the front of the pipe.
// Inputs : EX fields (ex_valid/ex_we/ex_is_load/ex_dst), MEM stage fields
//          (m_valid/m_we/m_load/m_dst), ID source operands and mem_ready.
// Outputs: m_we_e       - MEM stage holds a real write to a non-zero register
//          freeze       - load in MEM still waiting on memory
//          mem_load_use - ID depends on a load still waiting in MEM
//          stall        - hold PC and IF/ID
//          bubble_ex    - load a NOP into ID/EX next edge
module hazard_detect
  import core_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_we,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             m_valid,
  input  logic             m_we,
  input  logic             m_load,
  input  logic [REG_W-1:0] m_dst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             mem_ready,
  output logic             m_we_e,
  output logic             freeze,
  output logic             mem_load_use,
  output logic             stall,
  output logic             bubble_ex
);

  logic ex_we_e;
  logic load_use;

  assign ex_we_e = ex_valid & ex_we & (ex_dst != REG_ZERO);
  assign m_we_e  = m_valid & m_we & (m_dst != REG_ZERO);

  assign freeze = m_valid & m_load & ~mem_ready;

  assign load_use = ex_valid & ex_is_load & ex_we_e &
                    reg_hit(id_use_rs, id_use_rt, id_rs, id_rt, ex_dst);

  // Always covered by freeze; kept only so the top can assert that.
  assign mem_load_use = m_load & m_we_e & ~mem_ready &
                        reg_hit(id_use_rs, id_use_rt, id_rs, id_rt, m_dst);

  assign stall = load_use | freeze;

  // While frozen, EX must keep its instruction rather than lose it to a bubble.
  assign bubble_ex = load_use & ~freeze;

endmodule

// File: rtl/mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers of the MIPS core.
// Inputs : clk, rst (sync, active-high), EX stage outputs (ex_*), ID source
//          operands (id_*), data memory response (mem_rdata/mem_ready).
// Outputs: MEM forwarding source (mem_dst/mem_we/mem_data), WB forwarding
//          source and regfile write port (wb_dst/wb_we/wb_data), and the
//          front-end controls stall / bubble_ex.
module mem_wb_pipe #(
  // Must match core_pkg: the MEM stage record is built from stage_t.
  parameter int DATA_W = core_pkg::DATA_W,
  parameter int REG_W  = core_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_we,
  input  logic              ex_is_load,
  input  logic [REG_W-1:0]  ex_dst,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [REG_W-1:0]  mem_dst,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_data,
  output logic [REG_W-1:0]  wb_dst,
  output logic              wb_we,
  output logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              bubble_ex
);

  import core_pkg::stage_t;

  // MEM stage record
  stage_t            m_q;
  logic              m_valid;
  logic              m_we;
  logic              m_load;
  logic [REG_W-1:0]  m_dst;
  logic [DATA_W-1:0] m_res;

  // WB stage registers
  logic              w_we;
  logic [REG_W-1:0]  w_dst;
  logic [DATA_W-1:0] w_data;

  logic              m_we_e;
  logic              freeze;
  logic              mem_load_use;
  logic [DATA_W-1:0] m_value;

  assign m_valid = m_q.valid;
  assign m_we    = m_q.we;
  assign m_load  = m_q.load;
  assign m_dst   = m_q.dst;
  assign m_res   = m_q.data;

  // A load's value is whatever memory returns this cycle; everything else
  // carries the ALU result.
  assign m_value = m_load ? mem_rdata : m_res;

  hazard_detect u_hazard (
    .ex_valid     (ex_valid),
    .ex_we        (ex_we),
    .ex_is_load   (ex_is_load),
    .ex_dst       (ex_dst),
    .m_valid      (m_valid),
    .m_we         (m_we),
    .m_load       (m_load),
    .m_dst        (m_dst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .mem_ready    (mem_ready),
    .m_we_e       (m_we_e),
    .freeze       (freeze),
    .mem_load_use (mem_load_use),
    .stall        (stall),
    .bubble_ex    (bubble_ex)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q    <= '0;
      w_we   <= 1'b0;
      w_dst  <= '0;
      w_data <= '0;
    end else if (freeze) begin
      // MEM waits on memory; WB receives a bubble but keeps its last
      // address/data so the regfile port does not toggle needlessly.
      w_we <= 1'b0;
    end else begin
      m_q.valid <= ex_valid;
      m_q.we    <= ex_we;
      m_q.load  <= ex_is_load;
      m_q.dst   <= ex_dst;
      m_q.data  <= ex_result;
      w_we      <= m_we_e;
      w_dst     <= m_dst;
      w_data    <= m_value;
    end
  end

  // A dependency on a waiting load must already be stalling the front end.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!mem_load_use || freeze);
    end
  end

  assign mem_dst  = m_dst;
  assign mem_data = m_value;
  // A load is only forwardable once its data has actually arrived.
  assign mem_we   = m_we_e & (~m_load | mem_ready);

  assign wb_dst  = w_dst;
  assign wb_we   = w_we;
  assign wb_data = w_data;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed testbench for mem_wb_pipe. Inputs change 1 time unit after the
// rising edge; combinational outputs are checked 1 unit after that.
module tb_mem_wb_pipe;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_we;
  logic        ex_is_load;
  logic [4:0]  ex_dst;
  logic [31:0] ex_result;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [4:0]  mem_dst;
  logic        mem_we;
  logic [31:0] mem_data;
  logic [4:0]  wb_dst;
  logic        wb_we;
  logic [31:0] wb_data;
  logic        stall;
  logic        bubble_ex;

  int n_vec  = 0;
  int n_miss = 0;

  mem_wb_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_we      (ex_we),
    .ex_is_load (ex_is_load),
    .ex_dst     (ex_dst),
    .ex_result  (ex_result),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .mem_dst    (mem_dst),
    .mem_we     (mem_we),
    .mem_data   (mem_data),
    .wb_dst     (wb_dst),
    .wb_we      (wb_we),
    .wb_data    (wb_data),
    .stall      (stall),
    .bubble_ex  (bubble_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic we, input logic ld,
                        input logic [4:0] dst, input logic [31:0] res);
    ex_valid   = v;
    ex_we      = we;
    ex_is_load = ld;
    ex_dst     = dst;
    ex_result  = res;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt);
    id_rs     = rs;
    id_use_rs = urs;
    id_rt     = rt;
    id_use_rt = urt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_ex(1'b1, 1'b1, 1'b0, 5'd3, 32'hFFFF_FFFF);
    set_id(5'd1, 1'b0, 5'd2, 1'b0);
    mem_rdata = 32'hCAFE_F00D;
    mem_ready = 1'b1;
    step();
    step();
    #1;
    n_vec++; if (mem_dst !== 5'd0) begin n_miss++; $display("FAIL reset_mem_dst got=%0h exp=0", mem_dst); end
    n_vec++; if (mem_we !== 1'b0) begin n_miss++; $display("FAIL reset_mem_we got=%0h exp=0", mem_we); end
    n_vec++; if (mem_data !== 32'h0) begin n_miss++; $display("FAIL reset_mem_data got=%0h exp=0", mem_data); end
    n_vec++; if (wb_dst !== 5'd0) begin n_miss++; $display("FAIL reset_wb_dst got=%0h exp=0", wb_dst); end
    n_vec++; if (wb_we !== 1'b0) begin n_miss++; $display("FAIL reset_wb_we got=%0h exp=0", wb_we); end
    n_vec++; if (wb_data !== 32'h0) begin n_miss++; $display("FAIL reset_wb_data got=%0h exp=0", wb_data); end
    n_vec++; if (stall !== 1'b0) begin n_miss++; $display("FAIL reset_stall got=%0h exp=0", stall); end
    n_vec++; if (bubble_ex !== 1'b0) begin n_miss++; $display("FAIL reset_bubble got=%0h exp=0", bubble_ex); end
    set_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    mem_rdata = 32'h0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_alu_chain();
    set_ex(1'b1, 1'b1, 1'b0, 5'd3, 32'h10);
    set_id(5'd3, 1'b1, 5'd0, 1'b0);
    #1;
    n_vec++; if (stall !== 1'b0) begin n_miss++; $display("FAIL alu_stall_ex got=%0h exp=0", stall); end
    step();
    set_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    n_vec++; if (mem_dst !== 5'd3) begin n_miss++; $display("FAIL alu_mem_dst got=%0h exp=3", mem_dst); end
    n_vec++; if (mem_we !== 1'b1) begin n_miss++; $display("FAIL alu_mem_we got=%0h exp=1", mem_we); end
    n_vec++; if (mem_data !== 32'h10) begin n_miss++; $display("FAIL alu_mem_data got=%0h exp=10", mem_data); end
    n_vec++; if (stall !== 1'b0) begin n_miss++; $display("FAIL alu_stall_mem got=%0h exp=0", stall); end
    step();
    n_vec++; if (wb_we !== 1'b1) begin n_miss++; $display("FAIL alu_wb_we got=%0h exp=1", wb_we); end
    n_vec++; if (wb_dst !== 5'd3) begin n_miss++; $display("FAIL alu_wb_dst got=%0h exp=3", wb_dst); end
    n_vec++; if (wb_data !== 32'h10) begin n_miss++; $display("FAIL alu_wb_data got=%0h exp=10", wb_data); end
    n_vec++; if (mem_we !== 1'b0) begin n_miss++; $display("FAIL alu_mem_we_idle got=%0h exp=0", mem_we); end
    n_vec++; if (stall !== 1'b0) begin n_miss++; $display("FAIL alu_stall_wb got=%0h exp=0", stall); end
    set_id(5'd0, 1'b0, 5'd0, 1'b0);
    step();
  endtask

  task automatic test_load_use();
    mem_ready = 1'b1;
    set_ex(1'b1, 1'b1, 1'b1, 5'd5, 32'h100);
    set_id(5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    n_vec++; if (stall !== 1'b1) begin n_miss++; $display("FAIL lu_stall got=%0h exp=1", stall); end
    n_vec++; if (bubble_ex !== 1'b1) begin n_miss++; $display("FAIL lu_bubble got=%0h exp=1", bubble_ex); end
    step();
    set_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    mem_rdata = 32'hDEAD;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_miss++; $display("FAIL lu_stall_after got=%0h exp=0", stall); end
    n_vec++; if (bubble_ex !== 1'b0) begin n_miss++; $display("FAIL lu_bubble_after got=%0h exp=0", bubble_ex); end
    n_vec++; if (mem_dst !== 5'd5) begin n_miss++; $display("FAIL lu_mem_dst got=%0h exp=5", mem_dst); end
    n_vec++; if (mem_we !== 1'b1) begin n_miss++; $display("FAIL lu_mem_we got=%0h exp=1", mem_we); end
    n_vec++; if (mem_data !== 32'hDEAD) begin n_miss++; $display("FAIL lu_mem_data got=%0h exp=dead", mem_data); end
    step();
    n_vec++; if (wb_we !== 1'b1) begin n_miss++; $display("FAIL lu_wb_we got=%0h exp=1", wb_we); end
    n_vec++; if (wb_dst !== 5'd5) begin n_miss++; $display("FAIL lu_wb_dst got=%0h exp=5", wb_dst); end
    n_vec++; if (wb_data !== 32'hDEAD) begin n_miss++; $display("FAIL lu_wb_data got=%0h exp=dead", wb_data); end
    set_id(5'd0, 1'b0, 5'd0, 1'b0);
    step();
  endtask

  task automatic test_mem_wait();
    mem_ready = 1'b1;
    set_ex(1'b1, 1'b1, 1'b1, 5'd9, 32'h200);
    set_id(5'd9, 1'b0, 5'd0, 1'b0);
    #1;
    n_vec++; if (stall !== 1'b0) begin n_miss++; $display("FAIL mw_stall_ex got=%0h exp=0", stall); end
    step();
    // An add r4 sits in EX and must be held during the wait.
    set_ex(1'b1, 1'b1, 1'b0, 5'd4, 32'h44);
    mem_ready = 1'b0;
    mem_rdata = 32'hBAD;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++; if (stall !== 1'b1) begin n_miss++; $display("FAIL mw_stall_c%0d got=%0h exp=1", c, stall); end
      n_vec++; if (bubble_ex !== 1'b0) begin n_miss++; $display("FAIL mw_bubble_c%0d got=%0h exp=0", c, bubble_ex); end
      n_vec++; if (mem_we !== 1'b0) begin n_miss++; $display("FAIL mw_mem_we_c%0d got=%0h exp=0", c, mem_we); end
      step();
      n_vec++; if (mem_dst !== 5'd9) begin n_miss++; $display("FAIL mw_mem_dst_c%0d got=%0h exp=9", c, mem_dst); end
      n_vec++; if (wb_we !== 1'b0) begin n_miss++; $display("FAIL mw_wb_we_c%0d got=%0h exp=0", c, wb_we); end
    end
    mem_ready = 1'b1;
    mem_rdata = 32'h1234;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_miss++; $display("FAIL mw_stall_ready got=%0h exp=0", stall); end
    n_vec++; if (mem_we !== 1'b1) begin n_miss++; $display("FAIL mw_mem_we_ready got=%0h exp=1", mem_we); end
    n_vec++; if (mem_data !== 32'h1234) begin n_miss++; $display("FAIL mw_mem_data_ready got=%0h exp=1234", mem_data); end
    step();
    set_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    n_vec++; if (wb_we !== 1'b1) begin n_miss++; $display("FAIL mw_wb_we got=%0h exp=1", wb_we); end
    n_vec++; if (wb_dst !== 5'd9) begin n_miss++; $display("FAIL mw_wb_dst got=%0h exp=9", wb_dst); end
    n_vec++; if (wb_data !== 32'h1234) begin n_miss++; $display("FAIL mw_wb_data got=%0h exp=1234", wb_data); end
    n_vec++; if (mem_dst !== 5'd4) begin n_miss++; $display("FAIL mw_held_dst got=%0h exp=4", mem_dst); end
    n_vec++; if (mem_data !== 32'h44) begin n_miss++; $display("FAIL mw_held_data got=%0h exp=44", mem_data); end
    step();
  endtask

  task automatic test_r0_filter();
    mem_ready = 1'b1;
    set_ex(1'b1, 1'b1, 1'b1, 5'd0, 32'h300);
    set_id(5'd0, 1'b1, 5'd0, 1'b0);
    #1;
    n_vec++; if (stall !== 1'b0) begin n_miss++; $display("FAIL r0_stall got=%0h exp=0", stall); end
    n_vec++; if (bubble_ex !== 1'b0) begin n_miss++; $display("FAIL r0_bubble got=%0h exp=0", bubble_ex); end
    step();
    set_ex(1'b1, 1'b1, 1'b0, 5'd0, 32'h55);
    set_id(5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    n_vec++; if (mem_we !== 1'b0) begin n_miss++; $display("FAIL r0_lw_mem_we got=%0h exp=0", mem_we); end
    step();
    set_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    n_vec++; if (mem_we !== 1'b0) begin n_miss++; $display("FAIL r0_add_mem_we got=%0h exp=0", mem_we); end
    n_vec++; if (wb_we !== 1'b0) begin n_miss++; $display("FAIL r0_lw_wb_we got=%0h exp=0", wb_we); end
    step();
    n_vec++; if (wb_we !== 1'b0) begin n_miss++; $display("FAIL r0_add_wb_we got=%0h exp=0", wb_we); end
  endtask

  task automatic test_unused_operand();
    mem_ready = 1'b1;
    set_ex(1'b1, 1'b1, 1'b1, 5'd7, 32'h400);
    set_id(5'd1, 1'b1, 5'd7, 1'b0);
    #1;
    n_vec++; if (stall !== 1'b0) begin n_miss++; $display("FAIL unused_rt_stall got=%0h exp=0", stall); end
    id_use_rt = 1'b1;
    #1;
    n_vec++; if (stall !== 1'b1) begin n_miss++; $display("FAIL used_rt_stall got=%0h exp=1", stall); end
    n_vec++; if (bubble_ex !== 1'b1) begin n_miss++; $display("FAIL used_rt_bubble got=%0h exp=1", bubble_ex); end
    set_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    set_id(5'd0, 1'b0, 5'd0, 1'b0);
    step();
    step();
  endtask

  task automatic test_reset_mid_freeze();
    mem_ready = 1'b1;
    set_ex(1'b1, 1'b1, 1'b1, 5'd6, 32'h500);
    step();
    set_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    mem_ready = 1'b0;
    mem_rdata = 32'h7777;
    #1;
    n_vec++; if (stall !== 1'b1) begin n_miss++; $display("FAIL rf_stall_pre got=%0h exp=1", stall); end
    rst = 1'b1;
    step();
    n_vec++; if (stall !== 1'b0) begin n_miss++; $display("FAIL rf_stall got=%0h exp=0", stall); end
    n_vec++; if (mem_dst !== 5'd0) begin n_miss++; $display("FAIL rf_mem_dst got=%0h exp=0", mem_dst); end
    n_vec++; if (mem_data !== 32'h0) begin n_miss++; $display("FAIL rf_mem_data got=%0h exp=0", mem_data); end
    n_vec++; if (wb_we !== 1'b0) begin n_miss++; $display("FAIL rf_wb_we got=%0h exp=0", wb_we); end
    n_vec++; if (wb_dst !== 5'd0) begin n_miss++; $display("FAIL rf_wb_dst got=%0h exp=0", wb_dst); end
    n_vec++; if (wb_data !== 32'h0) begin n_miss++; $display("FAIL rf_wb_data got=%0h exp=0", wb_data); end
    rst = 1'b0;
    mem_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      n_vec++; if (wb_we !== 1'b0) begin n_miss++; $display("FAIL rf_no_write_c%0d got=%0h exp=0", c, wb_we); end
    end
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b1;
    set_id(5'd0, 1'b0, 5'd0, 1'b0);
    set_ex(1'b1, 1'b1, 1'b1, 5'd10, 32'hA0);
    step();
    set_ex(1'b1, 1'b1, 1'b1, 5'd11, 32'hB0);
    mem_rdata = 32'h1010;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_miss++; $display("FAIL b2b_stall got=%0h exp=0", stall); end
    n_vec++; if (mem_dst !== 5'd10) begin n_miss++; $display("FAIL b2b_mem_dst1 got=%0h exp=a", mem_dst); end
    n_vec++; if (mem_data !== 32'h1010) begin n_miss++; $display("FAIL b2b_mem_data1 got=%0h exp=1010", mem_data); end
    step();
    set_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    mem_rdata = 32'h1111;
    #1;
    n_vec++; if (mem_dst !== 5'd11) begin n_miss++; $display("FAIL b2b_mem_dst2 got=%0h exp=b", mem_dst); end
    n_vec++; if (mem_data !== 32'h1111) begin n_miss++; $display("FAIL b2b_mem_data2 got=%0h exp=1111", mem_data); end
    n_vec++; if (wb_we !== 1'b1) begin n_miss++; $display("FAIL b2b_wb_we1 got=%0h exp=1", wb_we); end
    n_vec++; if (wb_dst !== 5'd10) begin n_miss++; $display("FAIL b2b_wb_dst1 got=%0h exp=a", wb_dst); end
    n_vec++; if (wb_data !== 32'h1010) begin n_miss++; $display("FAIL b2b_wb_data1 got=%0h exp=1010", wb_data); end
    step();
    n_vec++; if (wb_we !== 1'b1) begin n_miss++; $display("FAIL b2b_wb_we2 got=%0h exp=1", wb_we); end
    n_vec++; if (wb_dst !== 5'd11) begin n_miss++; $display("FAIL b2b_wb_dst2 got=%0h exp=b", wb_dst); end
    n_vec++; if (wb_data !== 32'h1111) begin n_miss++; $display("FAIL b2b_wb_data2 got=%0h exp=1111", wb_data); end
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_mem_wait();
    test_r0_filter();
    test_unused_operand();
    test_reset_mid_freeze();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
